// File: rtl/match_fifo.sv
// Match-address capture FIFO for one search pass: buffers engine matches and drains them over valid/ready.
// Optional MATCH_DEDUP_EN: drop a match whose address repeats the last accepted one of this pass.
module match_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 8
) (
  input  logic          CLK100MHZ,
  input  logic          CPU_RESETN,
  input  logic          start,
  input  logic          match_valid,
  input  logic [AW-1:0] match_addr,
  input  logic          search_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic [7:0]    match_count,
  output logic          overflow,
  output logic          busy,
  output logic          finished
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    COLLECT = 4'b0010,
    DRAIN   = 4'b0100,
    DONE    = 4'b1000
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   rptr_q, wptr_q;
  logic [PW:0]     occ_q, occ_d;
  logic [7:0]      cnt_q;
  logic            ovf_q;
  logic            dup, accept, full, push, pop;

`ifdef MATCH_DEDUP_EN
  logic            last_vld_q;
  logic [AW-1:0]   last_addr_q;

  assign dup = last_vld_q && (match_addr == last_addr_q);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      last_vld_q  <= 1'b0;
      last_addr_q <= '0;
    end else if (start) begin
      last_vld_q  <= 1'b0;
    end else if (accept) begin
      last_vld_q  <= 1'b1;
      last_addr_q <= match_addr;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign busy        = (state_q == COLLECT) || (state_q == DRAIN);
  assign finished    = (state_q == DONE);
  assign out_valid   = busy && (occ_q != '0);
  assign out_last    = out_valid && (occ_q == (PW+1)'(1)) && (state_q == DRAIN);
  // Gate the head read so the bus reads zero whenever nothing is offered (incl. reset).
  assign out_addr    = out_valid ? mem_q[rptr_q] : '0;
  assign match_count = cnt_q;
  assign overflow    = ovf_q;

  always_comb begin
    full   = (occ_q == (PW+1)'(DEPTH));
    accept = (state_q == COLLECT) && match_valid && !start && !dup;
    pop    = out_valid && out_ready && !start;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    push   = accept && (!full || pop);
    occ_d  = occ_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (push) mem_q[wptr_q] <= match_addr;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= IDLE;
      rptr_q  <= '0;
      wptr_q  <= '0;
      occ_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (start) begin
      state_q <= COLLECT;
      rptr_q  <= '0;
      wptr_q  <= '0;
      occ_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      occ_q <= occ_d;
      if (accept && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
      if (accept && full && !pop)   ovf_q <= 1'b1;
      case (state_q)
        COLLECT: if (search_done) state_q <= DRAIN;
        DRAIN:   if (occ_d == '0) state_q <= DONE;
        default: state_q <= state_q;
      endcase
    end
  end
endmodule

// File: tb/tb_match_fifo.sv
// Directed bench for match_fifo: a vector table for the basic pass flows plus hand sequences for
// overflow, full push+pop, mid-pass restart, asynchronous reset and (optionally) address dedup.
module tb_match_fifo;
  logic       CLK100MHZ = 1'b0;
  logic       CPU_RESETN;
  logic       start, match_valid, search_done, out_ready;
  logic [7:0] match_addr;
  logic       out_valid, out_last, overflow, busy, finished;
  logic [7:0] out_addr, match_count;

  int n_chk  = 0;
  int n_fail = 0;

  match_fifo #(.DEPTH(16), .AW(8)) dut (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .start(start),
    .match_valid(match_valid), .match_addr(match_addr), .search_done(search_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_last(out_last), .match_count(match_count), .overflow(overflow),
    .busy(busy), .finished(finished)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {
    logic       st, mv;
    logic [7:0] a;
    logic       sd, rdy;
    logic       ev;
    logic [7:0] ea;
    logic       el;
    logic [7:0] ec;
    logic       eb, ef, eo;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge CLK100MHZ);
  endtask

  // Drive one cycle of inputs (called at a negedge), then take the rising edge.
  task automatic drv(input logic st, input logic mv, input logic [7:0] a,
                     input logic sd, input logic rdy);
    start = st; match_valid = mv; match_addr = a; search_done = sd; out_ready = rdy;
    @(posedge CLK100MHZ);
  endtask

  task automatic chk_head(input string name, input logic [7:0] ea, input logic el);
    chk({name, ".valid"}, 32'(out_valid), 32'd1);
    chk({name, ".addr"},  32'(out_addr),  32'(ea));
    chk({name, ".last"},  32'(out_last),  32'(el));
  endtask

  initial begin
    CPU_RESETN = 1'b0;
    start = 0; match_valid = 0; match_addr = 0; search_done = 0; out_ready = 0;

    //              st mv  a     sd rdy | ev ea    el ec     eb ef eo
    tbl[0]  = '{1'b0,1'b1,8'h99,1'b1,1'b0, 1'b0,8'h00,1'b0,8'd0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,1'b0,8'd0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,8'h05,1'b0,1'b0, 1'b0,8'h00,1'b0,8'd0,1'b1,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b1,8'h0C,1'b0,1'b0, 1'b1,8'h05,1'b0,8'd1,1'b1,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b1,8'h20,1'b0,1'b0, 1'b1,8'h05,1'b0,8'd2,1'b1,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,8'h00,1'b1,1'b0, 1'b1,8'h05,1'b0,8'd3,1'b1,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b0,8'h00,1'b0,1'b1, 1'b1,8'h05,1'b0,8'd3,1'b1,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b0,8'h00,1'b0,1'b1, 1'b1,8'h0C,1'b0,8'd3,1'b1,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b0,8'h00,1'b0,1'b1, 1'b1,8'h20,1'b1,8'd3,1'b1,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,1'b0,8'd3,1'b0,1'b1,1'b0};
    tbl[10] = '{1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,1'b0,8'd3,1'b0,1'b1,1'b0};
    tbl[11] = '{1'b0,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h00,1'b0,8'd0,1'b1,1'b0,1'b0};
    tbl[12] = '{1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,1'b0,8'd0,1'b1,1'b0,1'b0};
    tbl[13] = '{1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,1'b0,8'd0,1'b0,1'b1,1'b0};
    tbl[14] = '{1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,1'b0,8'd0,1'b0,1'b1,1'b0};
    tbl[15] = '{1'b0,1'b1,8'h33,1'b1,1'b0, 1'b0,8'h00,1'b0,8'd0,1'b1,1'b0,1'b0};
    tbl[16] = '{1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h33,1'b1,8'd1,1'b1,1'b0,1'b0};
    tbl[17] = '{1'b0,1'b0,8'h00,1'b0,1'b1, 1'b1,8'h33,1'b1,8'd1,1'b1,1'b0,1'b0};
    tbl[18] = '{1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,1'b0,8'd1,1'b0,1'b1,1'b0};
    tbl[19] = '{1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,1'b0,8'd1,1'b0,1'b1,1'b0};

    repeat (2) @(posedge CLK100MHZ);
    nxt();
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.addr",  32'(out_addr), 0);
    chk("rst.busy",  32'(busy), 0);
    chk("rst.fin",   32'(finished), 0);
    CPU_RESETN = 1'b1;
    @(posedge CLK100MHZ);

    // Outputs are register-only, so each row's expectations are the values seen before its edge.
    for (int i = 0; i < 20; i++) begin
      nxt();
      chk($sformatf("tbl%0d.valid", i), 32'(out_valid),   32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d.addr", i), 32'(out_addr), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d.last", i),  32'(out_last),    32'(tbl[i].el));
      chk($sformatf("tbl%0d.count", i), 32'(match_count), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d.busy", i),  32'(busy),        32'(tbl[i].eb));
      chk($sformatf("tbl%0d.fin", i),   32'(finished),    32'(tbl[i].ef));
      chk($sformatf("tbl%0d.ovf", i),   32'(overflow),    32'(tbl[i].eo));
      drv(tbl[i].st, tbl[i].mv, tbl[i].a, tbl[i].sd, tbl[i].rdy);
    end

    // Overflow: 20 pushes into 16 slots with the consumer stalled.
    nxt(); drv(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin nxt(); drv(0, 1, 8'(i), 0, 0); end
    nxt();
    chk("ovf.count", 32'(match_count), 20);
    chk("ovf.flag",  32'(overflow), 1);
    chk_head("ovf.head", 8'h00, 1'b0);
    drv(0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      nxt(); chk_head($sformatf("ovf.drain%0d", i), 8'(i), i == 15); drv(0, 0, 0, 0, 1);
    end
    nxt();
    chk("ovf.fin",    32'(finished), 1);
    chk("ovf.fvalid", 32'(out_valid), 0);

    // Full FIFO: push and pop in the same cycle.
    drv(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin nxt(); drv(0, 1, 8'h50 + 8'(i), 0, 0); end
    nxt();
    chk_head("full.head", 8'h50, 1'b0);
    drv(0, 1, 8'h40, 0, 1);
    nxt();
    chk("full.ovf",   32'(overflow), 0);
    chk("full.count", 32'(match_count), 17);
    drv(0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      nxt();
      chk_head($sformatf("full.drain%0d", i), (i < 15) ? 8'h51 + 8'(i) : 8'h40, i == 15);
      drv(0, 0, 0, 0, 1);
    end
    nxt();
    chk("full.fin", 32'(finished), 1);

    // Restart mid-COLLECT with queued entries and a set overflow flag.
    drv(1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin nxt(); drv(0, 1, 8'hA0 + 8'(i), 0, 0); end
    nxt();
    chk("rs.preovf", 32'(overflow), 1);
    drv(1, 1, 8'hEE, 0, 0);
    nxt();
    chk("rs.valid", 32'(out_valid), 0);
    chk("rs.count", 32'(match_count), 0);
    chk("rs.ovf",   32'(overflow), 0);
    chk("rs.busy",  32'(busy), 1);
    drv(0, 1, 8'h11, 0, 0);
    nxt(); chk_head("rs.h0", 8'h11, 1'b0); drv(0, 1, 8'h22, 0, 0);
    nxt(); drv(0, 0, 0, 1, 0);
    nxt(); chk_head("rs.d0", 8'h11, 1'b0); chk("rs.count2", 32'(match_count), 2); drv(0, 0, 0, 0, 1);
    nxt(); chk_head("rs.d1", 8'h22, 1'b1); drv(0, 0, 0, 0, 1);
    nxt(); chk("rs.fin", 32'(finished), 1);

    // Asynchronous reset in the middle of DRAIN.
    drv(1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin nxt(); drv(0, 1, 8'h60 + 8'(i), 0, 0); end
    nxt(); drv(0, 0, 0, 1, 0);
    nxt();
    chk("ar.busy0", 32'(busy), 1);
    chk_head("ar.head", 8'h60, 1'b0);
    CPU_RESETN = 1'b0;
    #2;
    chk("ar.valid", 32'(out_valid), 0);
    chk("ar.addr",  32'(out_addr), 0);
    chk("ar.last",  32'(out_last), 0);
    chk("ar.count", 32'(match_count), 0);
    chk("ar.ovf",   32'(overflow), 0);
    chk("ar.busy",  32'(busy), 0);
    chk("ar.fin",   32'(finished), 0);
    nxt();
    CPU_RESETN = 1'b1;
    drv(0, 1, 8'h77, 1, 0);
    nxt();
    chk("ar.idle_busy",  32'(busy), 0);
    chk("ar.idle_count", 32'(match_count), 0);
    chk("ar.idle_fin",   32'(finished), 0);
    drv(0, 0, 0, 0, 0);

`ifdef MATCH_DEDUP_EN
    nxt(); drv(1, 0, 0, 0, 0);
    nxt(); drv(0, 1, 8'h07, 0, 0);
    nxt(); drv(0, 1, 8'h07, 0, 0);
    nxt(); drv(0, 1, 8'h09, 0, 0);
    nxt(); drv(0, 0, 0, 1, 0);
    nxt(); chk("dd.count", 32'(match_count), 2); chk_head("dd.d0", 8'h07, 1'b0); drv(0, 0, 0, 0, 1);
    nxt(); chk_head("dd.d1", 8'h09, 1'b1); drv(0, 0, 0, 0, 1);
    nxt(); chk("dd.fin", 32'(finished), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/match_fifo.md
Name: match_fifo

Overview:
- Downstream stage of the pattern-search engine. It captures every match address the engine reports during one search pass.
- Addresses are buffered in a small synchronous FIFO and drained to the consumer (seven-segment or UART formatter) over a valid/ready stream, with last-entry marking.
- Keeps a running match count and a sticky overflow flag, and reports when the pass is fully drained.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- AW, 8, match address width in bits.

Ports:
- CLK100MHZ  in  1  system clock; all logic on rising edge.
- CPU_RESETN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: flush FIFO, clear count and flags, begin a new pass.
- match_valid  in  1  one-cycle strobe: match_addr holds a new match.
- match_addr  in  AW  start address of the match in data memory.
- search_done  in  1  level or pulse from the engine: pass finished, no further matches.
- out_valid  out  1  out_addr/out_last are valid.
- out_ready  in  1  consumer accepts the entry when out_valid && out_ready.
- out_addr  out  AW  head-of-FIFO match address.
- out_last  out  1  head entry is the final entry of the pass.
- match_count  out  8  total matches reported this pass; saturates at 255.
- overflow  out  1  sticky; at least one match was dropped because the FIFO was full.
- busy  out  1  high in COLLECT or DRAIN.
- finished  out  1  high in DONE.

Behaviour:
- Reset (CPU_RESETN low, asynchronous):
  - state=IDLE; read/write pointers and occupancy = 0.
  - All outputs = 0, including out_addr.
  - Deassertion is taken on a clock edge.
- States (one-hot): IDLE, COLLECT, DRAIN, DONE.
  - IDLE: match_valid and search_done ignored. start -> COLLECT.
  - COLLECT: push on match_valid. search_done -> DRAIN. start -> flush and stay in COLLECT.
  - DRAIN: no pushes; match_valid ignored. Occupancy reaches 0 (including via a pop in this cycle) -> DONE. start -> flush, COLLECT.
  - DONE: finished=1; out_valid=0. start -> flush, COLLECT.
- Flush on start: pointers, occupancy, match_count and overflow cleared in the same edge. A match_valid in the start cycle is discarded.
- Push (COLLECT && match_valid):
  - match_count increments, saturating.
  - If full and no pop this cycle: entry dropped, overflow<=1.
  - Otherwise written at wptr; wptr wraps modulo DEPTH.
- Pop (out_valid && out_ready): rptr advances and wraps modulo DEPTH.
- Simultaneous push and pop:
  - When full: both occur, occupancy unchanged, no overflow.
  - When empty: no pop (out_valid low); push only.
- Latency and ordering:
  - Pushed entry visible on out_valid/out_addr on the cycle after the push edge.
  - out_addr is the registered/array-read head and is stable while out_valid && !out_ready.
- out_last = out_valid && occupancy==1 && state==DRAIN.
  - Never asserted in COLLECT, even for a single entry, because more matches may follow.
  - If search_done arrives with match_valid in the same cycle: that match is pushed first, then the state moves to DRAIN.
- Zero matches: COLLECT -> DRAIN -> DONE with out_valid never asserted and match_count=0.
- busy and finished are mutually exclusive; both are low in IDLE.

Optional Feature:
- Macro: MATCH_DEDUP_EN.
- Defined:
  - A match_valid whose match_addr equals the last accepted address of this pass is ignored: no push, no count.
  - The last-address register is invalidated on start and reset.
  - This suppresses repeat strobes of a held address.
- Undefined: every match_valid in COLLECT is pushed and counted. The register and comparator are not built.

Test Plan:
- Reset, then start; push 0x05, 0x0C, 0x20; search_done; out_ready=1 -> out_addr 0x05, 0x0C, 0x20 in order, out_last only on 0x20, match_count=3, finished 1 cycle after the last pop.
- start, then search_done with no matches -> out_valid never high, match_count=0, finished=1, overflow=0.
- DEPTH=16, out_ready=0, push 20 matches 0x00..0x13 -> full after 16, overflow=1, match_count=20; drain yields 0x00..0x0F with out_last on 0x0F.
- FIFO full, out_ready=1, push 0x40 in the same cycle as a pop -> no overflow, occupancy stays 16, 0x40 emerges last.
- Mid-COLLECT with 3 entries queued, pulse start -> out_valid=0 next cycle, match_count=0, overflow=0, busy=1; new pushes emerge first.
- CPU_RESETN low mid-DRAIN -> all outputs 0 immediately without a clock, state IDLE. With MATCH_DEDUP_EN: pushes 0x07, 0x07, 0x09 -> match_count=2, drained 0x07, 0x09.
